unit_issue_ctrl: RTL

Initiator side of the Start/Busy multicycle handshake. It sits between the decode/execute stage and the two multicycle responders, MCycle (integer multiply/divide) and FPUnit (floating point). It accepts one request from the pipeline, steers it to the selected unit, and issues a one-cycle Start with operands held stable. It stalls the pipeline while the unit is Busy, then captures the result and returns it with a Done pulse.

---
 rtl/unit_issue_pkg.sv | 18 +
 rtl/issue_wait_tracker.sv | 65 ++++++
 rtl/unit_issue_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/unit_issue_pkg.sv
// Shared definitions for the Start/Busy issue controller: FSM encoding,
// unit-select values and default configuration.
package unit_issue_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic SEL_MC = 1'b0;
  localparam logic SEL_FP = 1'b1;

  localparam int unsigned BUSY_GRACE_DEFAULT = 2;
  localparam int unsigned TIMEOUT_DEFAULT    = 256;

endpackage

// File: rtl/issue_wait_tracker.sv
// Tracks completion of the in-flight op while the controller waits on Busy.
// Optional watchdog compiled in with ISSUE_TIMEOUT_EN.
module issue_wait_tracker
  import unit_issue_pkg::*;
#(
  parameter int unsigned BUSY_GRACE = BUSY_GRACE_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_wait,
  input  logic busy,
  output logic op_complete_c,
  output logic timeout_c
);

  localparam int unsigned GW = (BUSY_GRACE > 1) ? $clog2(BUSY_GRACE + 1) : 1;
  localparam logic [GW-1:0] GRACE_LAST = GW'(BUSY_GRACE - 1);

  logic          seen_busy;
  logic [GW-1:0] grace_cnt;

  // Responders that never raise Busy are treated as done after the grace window.
  assign op_complete_c = in_wait && !busy && (seen_busy || (grace_cnt == GRACE_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_busy <= 1'b0;
      grace_cnt <= '0;
    end else if (clear) begin
      seen_busy <= 1'b0;
      grace_cnt <= '0;
    end else if (in_wait) begin
      if (busy) begin
        seen_busy <= 1'b1;
      end else if (!seen_busy && (grace_cnt != GRACE_LAST)) begin
        grace_cnt <= grace_cnt + GW'(1);
      end
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (clear) begin
      wd_cnt <= '0;
    end else if (in_wait) begin
      wd_cnt <= wd_cnt + TW'(1);
    end
  end

  assign timeout_c = in_wait && (wd_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_c      = 1'b0;
`endif

endmodule

// File: rtl/unit_issue_ctrl.sv
// Initiator side of the Start/Busy handshake towards MCycle and FPUnit.
// Define ISSUE_TIMEOUT_EN to enable the WAIT watchdog and the Err flag.
module unit_issue_ctrl
  import unit_issue_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned BUSY_GRACE = BUSY_GRACE_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Req,
  input  logic             ReqSel,
  input  logic             ReqOp,
  input  logic [width-1:0] ReqA,
  input  logic [width-1:0] ReqB,
  output logic             Stall,
  output logic             Done,
  output logic [width-1:0] ResultOut,
  output logic             Err,
  output logic             MC_Start,
  output logic             FP_Start,
  output logic             UnitOp,
  output logic [width-1:0] Operand1,
  output logic [width-1:0] Operand2,
  input  logic             MC_Busy,
  input  logic             FP_Busy,
  input  logic [width-1:0] MC_Result,
  input  logic [width-1:0] FP_Result
);

  state_t state_q, state_d;
  logic   sel_q;
  logic   accept_c, capture_c, busy_c, op_complete_c, timeout_c;

  // Only the selected unit's handshake is observed.
  assign busy_c = (sel_q == SEL_FP) ? FP_Busy : MC_Busy;

  issue_wait_tracker #(
    .BUSY_GRACE (BUSY_GRACE),
    .TIMEOUT    (TIMEOUT)
  ) u_tracker (
    .clk           (CLK),
    .rst_n         (RESETn),
    .clear         (state_q == S_ISSUE),
    .in_wait       (state_q == S_WAIT),
    .busy          (busy_c),
    .op_complete_c (op_complete_c),
    .timeout_c     (timeout_c)
  );

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          accept_c = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (op_complete_c) begin
          capture_c = 1'b1;
          state_d   = S_DONE;
        end else if (timeout_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign Stall = ((state_q == S_IDLE) && Req) || (state_q == S_ISSUE) || (state_q == S_WAIT);

  // Operands and op are latched only on acceptance so they hold through DONE.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sel_q     <= SEL_MC;
      UnitOp    <= 1'b0;
      Operand1  <= '0;
      Operand2  <= '0;
      ResultOut <= '0;
      MC_Start  <= 1'b0;
      FP_Start  <= 1'b0;
      Done      <= 1'b0;
    end else begin
      MC_Start <= accept_c && (ReqSel == SEL_MC);
      FP_Start <= accept_c && (ReqSel == SEL_FP);
      Done     <= (state_q == S_WAIT) && (state_d == S_DONE);
      if (accept_c) begin
        sel_q    <= ReqSel;
        UnitOp   <= ReqOp;
        Operand1 <= ReqA;
        Operand2 <= ReqB;
      end
      if (capture_c) begin
        ResultOut <= (sel_q == SEL_FP) ? FP_Result : MC_Result;
      end
    end
  end

`ifdef ISSUE_TIMEOUT_EN
  // Err marks a watchdog abort and holds until the next acceptance.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      Err <= 1'b0;
    end else if (accept_c) begin
      Err <= 1'b0;
    end else if ((state_q == S_WAIT) && timeout_c && !op_complete_c) begin
      Err <= 1'b1;
    end
  end
`else
  assign Err = 1'b0;
`endif

endmodule
